// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: fetches words over a valid/ready handshake, latches the IR
// and sequences FETCH/DECODE/EXEC/MEM/WB with combinational control decoded from {state, IR}.
module mips_multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr_word,
    output logic [31:0]      instruction,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             ALUScr,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic [3:0]       ALUControl,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             branch_taken,
    output logic             instr_done,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] cnt_q;

    logic [5:0] op, funct;
    logic       is_lw, is_sw, is_beq, is_addi, is_r, supported;
    logic [3:0] r_alu;

    assign op      = ir_q[31:26];
    assign funct   = ir_q[5:0];
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_addi = (op == 6'b001000);

    always_comb begin
        is_r  = 1'b0;
        r_alu = 4'b0010;
        if (op == 6'b000000) begin
            is_r = 1'b1;
            case (funct)
                6'b100000: r_alu = 4'b0010;
                6'b100010: r_alu = 4'b0110;
                6'b100100: r_alu = 4'b0000;
                6'b100101: r_alu = 4'b0001;
                6'b101010: r_alu = 4'b0111;
                default:   is_r  = 1'b0;
            endcase
        end
    end

    assign supported = is_lw | is_sw | is_beq | is_addi | is_r;

    // Handshake: a word transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in FETCH and only while out of reset.
    always_comb begin
        state_d      = state_q;
        instr_ready  = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        ALUScr       = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        ALUControl   = 4'b0010;
        branch_taken = 1'b0;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        // ALU setup established in EXEC is held through MEM and WB.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            ALUScr     = is_lw | is_sw | is_addi;
            ALUControl = is_beq ? 4'b0110 : (is_r ? r_alu : 4'b0010);
        end
        case (state_q)
            S_FETCH: begin
                instr_ready = rst;
                if (instr_valid && rst) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (supported) begin
                    state_d = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    branch_taken = Zero;
                    instr_done   = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                RegDst     = is_r;
                MemtoReg   = is_lw;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            ir_q    <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (IRWrite) ir_q <= instr_word;
            if (instr_done) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign instruction = ir_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: a CNT_W=16 instance for the main checks and
// a CNT_W=2 instance on the same inputs for counter wrap.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic        Zero;
    logic        mem_ready;

    logic        instr_ready, ALUScr, RegDst, RegWrite, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, PCWrite, branch_taken, instr_done, illegal;
    logic [31:0] instruction;
    logic [3:0]  ALUControl;
    logic [2:0]  state;
    logic [15:0] instr_count;

    logic        w_instr_ready, w_ALUScr, w_RegDst, w_RegWrite, w_MemRead, w_MemWrite, w_MemtoReg;
    logic        w_IRWrite, w_PCWrite, w_branch_taken, w_instr_done, w_illegal;
    logic [31:0] w_instruction;
    logic [3:0]  w_ALUControl;
    logic [2:0]  w_state;
    logic [1:0]  w_instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_word(instr_word), .instruction(instruction), .Zero(Zero), .mem_ready(mem_ready),
        .ALUScr(ALUScr), .RegDst(RegDst), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUControl(ALUControl), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .branch_taken(branch_taken), .instr_done(instr_done),
        .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    mips_multicycle_control #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(w_instr_ready),
        .instr_word(instr_word), .instruction(w_instruction), .Zero(Zero), .mem_ready(mem_ready),
        .ALUScr(w_ALUScr), .RegDst(w_RegDst), .RegWrite(w_RegWrite), .MemRead(w_MemRead),
        .MemWrite(w_MemWrite), .MemtoReg(w_MemtoReg), .ALUControl(w_ALUControl),
        .IRWrite(w_IRWrite), .PCWrite(w_PCWrite), .branch_taken(w_branch_taken),
        .instr_done(w_instr_done), .illegal(w_illegal), .state(w_state),
        .instr_count(w_instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FETCH cycle with handshake, leaves the bench in DECODE
    task automatic fetch(input logic [31:0] w);
        instr_valid = 1'b1;
        instr_word  = w;
        #1;
        chk("fetch_state", state, 0);
        chk("fetch_ready", instr_ready, 1);
        chk("fetch_irwrite", IRWrite, 1);
        chk("fetch_pcwrite", PCWrite, 1);
        tick();
        instr_valid = 1'b0;
        instr_word  = 32'hDEAD_BEEF;
        #1;
        chk("decode_state", state, 1);
        chk("decode_ir", instruction, w);
    endtask

    // Four-cycle R-type with expected ALU op and counter after retirement
    task automatic r_type(input logic [31:0] w, input logic [3:0] alu, input int cnt);
        fetch(w);
        chk("r_decode_illegal", illegal, 0);
        tick();
        chk("r_exec_state", state, 2);
        chk("r_exec_aluscr", ALUScr, 0);
        chk("r_exec_aluctl", ALUControl, alu);
        chk("r_exec_regwrite", RegWrite, 0);
        tick();
        chk("r_wb_state", state, 4);
        chk("r_wb_regwrite", RegWrite, 1);
        chk("r_wb_regdst", RegDst, 1);
        chk("r_wb_memtoreg", MemtoReg, 0);
        chk("r_wb_aluctl", ALUControl, alu);
        chk("r_wb_done", instr_done, 1);
        tick();
        chk("r_back_fetch", state, 0);
        chk("r_regwrite_off", RegWrite, 0);
        chk("r_count", instr_count, cnt);
    endtask

    // Strobes must only appear in their own states
    always @(negedge clk) begin
        if (RegWrite && state != 3'd4) chk("regwrite_outside_wb", state, 4);
        if ((MemRead || MemWrite) && state != 3'd3) chk("mem_outside_mem", state, 3);
    end

    initial begin
        rst = 1'b0; instr_valid = 1'b0; instr_word = 32'd0; Zero = 1'b0; mem_ready = 1'b0;
        #2;
        chk("rst_state", state, 0);
        chk("rst_ready", instr_ready, 0);
        chk("rst_ir", instruction, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_aluctl", ALUControl, 4'b0010);
        chk("rst_regwrite", RegWrite, 0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("ready_after_rst", instr_ready, 1);

        // LW with mem_ready high: 5 cycles
        mem_ready = 1'b1;
        fetch(32'h8C08_0005);
        tick();
        chk("lw_exec_state", state, 2);
        chk("lw_exec_aluscr", ALUScr, 1);
        tick();
        chk("lw_mem_state", state, 3);
        chk("lw_mem_memread", MemRead, 1);
        chk("lw_mem_memwrite", MemWrite, 0);
        chk("lw_mem_aluscr", ALUScr, 1);
        chk("lw_mem_aluctl", ALUControl, 4'b0010);
        chk("lw_mem_done", instr_done, 0);
        tick();
        chk("lw_wb_state", state, 4);
        chk("lw_wb_regwrite", RegWrite, 1);
        chk("lw_wb_memtoreg", MemtoReg, 1);
        chk("lw_wb_regdst", RegDst, 0);
        chk("lw_wb_done", instr_done, 1);
        chk("lw_wb_memread", MemRead, 0);
        tick();
        chk("lw_back_fetch", state, 0);
        chk("lw_count", instr_count, 1);
        mem_ready = 1'b0;

        // ADD then SUB
        r_type(32'h0232_4820, 4'b0010, 2);
        r_type(32'h0232_5022, 4'b0110, 3);

        // SW with three stall cycles
        fetch(32'hAC09_000A);
        tick();
        chk("sw_exec_aluscr", ALUScr, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sw_stall_state", state, 3);
            chk("sw_stall_memwrite", MemWrite, 1);
            chk("sw_stall_done", instr_done, 0);
            chk("sw_stall_regwrite", RegWrite, 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_mem_state", state, 3);
        chk("sw_mem_memwrite", MemWrite, 1);
        chk("sw_mem_done", instr_done, 1);
        tick();
        mem_ready = 1'b0;
        chk("sw_back_fetch", state, 0);
        chk("sw_memwrite_off", MemWrite, 0);
        chk("sw_count", instr_count, 4);

        // BEQ taken then not taken
        Zero = 1'b1;
        fetch(32'h110B_0004);
        tick();
        chk("beq1_exec_state", state, 2);
        chk("beq1_aluctl", ALUControl, 4'b0110);
        chk("beq1_aluscr", ALUScr, 0);
        chk("beq1_taken", branch_taken, 1);
        chk("beq1_done", instr_done, 1);
        tick();
        chk("beq1_back_fetch", state, 0);
        chk("beq1_count", instr_count, 5);
        Zero = 1'b0;
        fetch(32'h110B_0004);
        tick();
        chk("beq0_taken", branch_taken, 0);
        chk("beq0_done", instr_done, 1);
        tick();
        chk("beq0_back_fetch", state, 0);
        chk("beq0_count", instr_count, 6);

        // Illegal opcode
        fetch(32'hFC00_0000);
        chk("ill_pulse", illegal, 1);
        chk("ill_done", instr_done, 0);
        chk("ill_regwrite", RegWrite, 0);
        chk("ill_memwrite", MemWrite, 0);
        tick();
        chk("ill_back_fetch", state, 0);
        chk("ill_pulse_off", illegal, 0);
        chk("ill_count", instr_count, 6);

        // Reset during LW MEM stall
        fetch(32'h8C08_0005);
        tick(); tick();
        chk("abort_mem_state", state, 3);
        chk("abort_memread", MemRead, 1);
        rst = 1'b0;
        instr_valid = 1'b1;
        #1;
        chk("abort_state", state, 0);
        chk("abort_memread_off", MemRead, 0);
        chk("abort_ready", instr_ready, 0);
        chk("abort_irwrite", IRWrite, 0);
        tick();
        chk("abort_ready_held", instr_ready, 0);
        chk("abort_count", instr_count, 0);
        instr_valid = 1'b0;
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("abort_ready_back", instr_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_regwrite", RegWrite, 0);
            chk("abort_idle_state", state, 0);
        end
        mem_ready = 1'b0;
        chk("abort_count_after", instr_count, 0);

        // Counter wrap on the CNT_W=2 instance
        r_type(32'h0232_4820, 4'b0010, 1);
        chk("wrap_1", w_instr_count, 1);
        r_type(32'h0232_4820, 4'b0010, 2);
        chk("wrap_2", w_instr_count, 2);
        r_type(32'h0232_4820, 4'b0010, 3);
        chk("wrap_3", w_instr_count, 3);
        r_type(32'h0232_4820, 4'b0010, 4);
        chk("wrap_0", w_instr_count, 0);
        r_type(32'h0232_4820, 4'b0010, 5);
        chk("wrap_1b", w_instr_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
